// File: rtl/fc_layer_seq.sv
// fc_layer_seq: walks weight/bias RAM and input buffer, accumulates one dot product per neuron,
// adds bias, saturates and streams results. Define FC_RELU_EN to clamp negative results to zero.
module fc_layer_seq #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 30,
    parameter int unsigned IN_ADDR_WIDTH = 10,
    parameter int unsigned N_IN          = 784,
    parameter int unsigned N_OUT         = 400,
    parameter int unsigned W_BASE        = 0,
    parameter int unsigned B_BASE        = 313600,
    parameter int unsigned FRAC_BITS     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     w_rd,
    output logic [ADDR_WIDTH-1:0]    w_addr,
    input  logic [DATA_WIDTH-1:0]    w_data,
    output logic                     x_rd,
    output logic [IN_ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0]    x_data,
    output logic                     y_valid,
    output logic [15:0]              y_idx,
    output logic [DATA_WIDTH-1:0]    y_data
);
    localparam int unsigned ACC_W = 2 * DATA_WIDTH;
    localparam int unsigned IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned JW    = 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_BIAS, S_ADD, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d;
    logic [JW-1:0]            j_q, j_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]    wptr_q, wptr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     w_rd_q, w_rd_d;
    logic [ADDR_WIDTH-1:0]    w_addr_q, w_addr_d;
    logic                     x_rd_q, x_rd_d;
    logic [IN_ADDR_WIDTH-1:0] x_addr_q, x_addr_d;
    logic                     y_valid_q, y_valid_d;
    logic [JW-1:0]            y_idx_q, y_idx_d;
    logic [DATA_WIDTH-1:0]    y_data_q, y_data_d;

    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  prod_sh;
    logic signed [ACC_W-1:0]  sum;
    logic [DATA_WIDTH-1:0]    sat;

    // Fixed-point product, bias sum and saturation datapath
    always_comb begin
        prod    = $signed({{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data})
                * $signed({{DATA_WIDTH{x_data[DATA_WIDTH-1]}}, x_data});
        prod_sh = prod >>> FRAC_BITS;
        sum     = acc_q + $signed({{DATA_WIDTH{w_data[DATA_WIDTH-1]}}, w_data});
        if (sum > SAT_MAX) begin
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat = sum[DATA_WIDTH-1:0];
        end
`ifdef FC_RELU_EN
        if (sat[DATA_WIDTH-1]) begin
            sat = '0;
        end
`endif
    end

    // Next-state, counters and registered-output next values
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        wptr_d    = wptr_q;
        y_valid_d = 1'b0;
        y_idx_d   = y_idx_q;
        y_data_d  = y_data_q;
        w_addr_d  = w_addr_q;
        x_addr_d  = x_addr_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        w_rd_d    = 1'b0;
        x_rd_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    wptr_d  = ADDR_WIDTH'(W_BASE);
                end
            end
            S_RUN: begin
                if (i_q != '0) begin
                    acc_d = acc_q + prod_sh;
                end
                wptr_d = wptr_q + ADDR_WIDTH'(1);
                if (i_q == IW'(N_IN - 1)) begin
                    state_d = S_BIAS;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            S_BIAS: begin
                acc_d   = acc_q + prod_sh;
                state_d = S_ADD;
            end
            S_ADD: begin
                y_valid_d = 1'b1;
                y_idx_d   = j_q;
                y_data_d  = sat;
                if (j_q == JW'(N_OUT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    j_d     = j_q + JW'(1);
                    i_d     = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and addresses are registered, so they describe the state being entered
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        w_rd_d = (state_d == S_RUN) || (state_d == S_BIAS);
        x_rd_d = (state_d == S_RUN);
        if (state_d == S_RUN) begin
            w_addr_d = wptr_d;
            x_addr_d = IN_ADDR_WIDTH'(i_d);
        end else if (state_d == S_BIAS) begin
            w_addr_d = ADDR_WIDTH'(B_BASE) + ADDR_WIDTH'(j_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            wptr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_rd_q    <= 1'b0;
            w_addr_q  <= '0;
            x_rd_q    <= 1'b0;
            x_addr_q  <= '0;
            y_valid_q <= 1'b0;
            y_idx_q   <= '0;
            y_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            wptr_q    <= wptr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            w_rd_q    <= w_rd_d;
            w_addr_q  <= w_addr_d;
            x_rd_q    <= x_rd_d;
            x_addr_q  <= x_addr_d;
            y_valid_q <= y_valid_d;
            y_idx_q   <= y_idx_d;
            y_data_q  <= y_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign w_rd    = w_rd_q;
    assign w_addr  = w_addr_q;
    assign x_rd    = x_rd_q;
    assign x_addr  = x_addr_q;
    assign y_valid = y_valid_q;
    assign y_idx   = y_idx_q;
    assign y_data  = y_data_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: behavioural schedule/arithmetic model with per-cycle compare,
// literal spot checks, and a second small instance for the fixed-point case.
module tb_fc_layer_seq;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int WB = 16;
    localparam int BB = 100;
    localparam int FB = 0;
    localparam int PER = NI + 2;
    localparam int T_DONE = 1 + NO * PER;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic b_start = 1'b0;

    logic        busy, done, w_rd, x_rd, y_valid;
    logic [29:0] w_addr;
    logic [9:0]  x_addr;
    logic [31:0] w_data = '0, x_data = '0, y_data;
    logic [15:0] y_idx;

    logic        b_busy, b_done, b_w_rd, b_x_rd, b_y_valid;
    logic [29:0] b_w_addr;
    logic [9:0]  b_x_addr;
    logic [31:0] b_w_data = '0, b_x_data = '0, b_y_data;
    logic [15:0] b_y_idx;

    always #5 clk = ~clk;

    fc_layer_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(30), .IN_ADDR_WIDTH(10), .N_IN(NI), .N_OUT(NO),
                   .W_BASE(WB), .B_BASE(BB), .FRAC_BITS(FB)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
        .x_rd(x_rd), .x_addr(x_addr), .x_data(x_data),
        .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data));

    fc_layer_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(30), .IN_ADDR_WIDTH(10), .N_IN(1), .N_OUT(1),
                   .W_BASE(0), .B_BASE(1), .FRAC_BITS(16)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .w_rd(b_w_rd), .w_addr(b_w_addr), .w_data(b_w_data),
        .x_rd(b_x_rd), .x_addr(b_x_addr), .x_data(b_x_data),
        .y_valid(b_y_valid), .y_idx(b_y_idx), .y_data(b_y_data));

    // Memories with 1-cycle synchronous read
    logic [31:0] mem [0:127];
    logic [31:0] xbuf [0:3];
    always @(posedge clk) begin
        if (w_rd) w_data <= (w_addr < 30'd128) ? mem[w_addr[6:0]] : 32'hDEADBEEF;
        if (x_rd) x_data <= (x_addr < 10'd4) ? xbuf[x_addr[1:0]] : 32'hDEADBEEF;
        if (b_w_rd) b_w_data <= (b_w_addr == 30'd0) ? 32'h0001_8000 :
                                (b_w_addr == 30'd1) ? 32'h0000_8000 : 32'hDEADBEEF;
        if (b_x_rd) b_x_data <= (b_x_addr == 10'd0) ? 32'h0002_0000 : 32'hDEADBEEF;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference arithmetic: truncating fixed-point dot product, bias, saturation
    function automatic logic [31:0] model_y(input int j);
        longint s = 0;
        for (int i = 0; i < NI; i++) begin
            longint w = longint'($signed(mem[WB + j * NI + i]));
            longint x = longint'($signed(xbuf[i]));
            s += (w * x) >>> FB;
        end
        s += longint'($signed(mem[BB + j]));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    // Model state: pass start cycle and expected results
    int          cyc = 0;
    int          c0 = 0;
    bit          active = 0;
    bit          armed = 0;
    bit          addr_zero = 0;
    logic [31:0] exp_y [0:NO-1];
    logic [31:0] m_yd = '0;
    logic [15:0] m_yi = '0;

    always @(posedge clk) begin
        if (rst) begin
            active = 0; armed = 1; addr_zero = 1; m_yd = '0; m_yi = '0;
        end else if (active && (cyc - c0) == T_DONE) begin
            active = 0;
        end else if (!active && start) begin
            active = 1; c0 = cyc; addr_zero = 0;
            for (int j = 0; j < NO; j++) exp_y[j] = model_y(j);
        end
        cyc++;
    end

    // Event log for literal checks
    int          lg_n = 0;
    int          lg_rel [0:7];
    logic [31:0] lg_d [0:7];
    logic [15:0] lg_i [0:7];
    int          done_rel = -1;
    int          done_cnt = 0;

    always @(negedge clk) begin : cmp
        int rel, k, jr;
        logic e_busy, e_done, e_yv, e_wrd, e_xrd;
        if (armed) begin
            rel = cyc - c0;
            k = (rel - 1) % PER;
            jr = (rel - 1) / PER;
            e_busy = active;
            e_done = active && (rel == T_DONE);
            e_yv = active && (rel > 1) && (k == 0);
            if (e_yv) begin
                m_yd = exp_y[jr - 1];
                m_yi = 16'(jr - 1);
            end
            e_wrd = active && (jr < NO) && (k <= NI);
            e_xrd = active && (jr < NO) && (k < NI);
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("y_valid", 64'(y_valid), 64'(e_yv));
            chk("y_data", 64'(y_data), 64'(m_yd));
            chk("y_idx", 64'(y_idx), 64'(m_yi));
            chk("w_rd", 64'(w_rd), 64'(e_wrd));
            chk("x_rd", 64'(x_rd), 64'(e_xrd));
            if (e_wrd) chk("w_addr", 64'(w_addr), (k < NI) ? 64'(WB + jr * NI + k) : 64'(BB + jr));
            if (e_xrd) chk("x_addr", 64'(x_addr), 64'(k));
            if (addr_zero) begin
                chk("w_addr_rst", 64'(w_addr), 64'(0));
                chk("x_addr_rst", 64'(x_addr), 64'(0));
            end
            if (y_valid === 1'b1 && lg_n < 8) begin
                lg_rel[lg_n] = rel; lg_d[lg_n] = y_data; lg_i[lg_n] = y_idx; lg_n++;
            end
            if (done === 1'b1) begin
                done_rel = rel; done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        lg_n = 0; done_rel = -1; done_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            lg_rel[n] = -1; lg_d[n] = 'x; lg_i[n] = 'x;
        end
    endtask

    task automatic start_pulse();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (done !== 1'b1 && n < budget);
        chk("done_timeout", 64'(done !== 1'b1), 64'(0));
    endtask

    task automatic fill_basic();
        for (int a = 0; a < NI * NO; a++) mem[WB + a] = 32'd1;
        mem[BB] = 32'd10;
        mem[BB + 1] = 32'hFFFF_FFEC;
        for (int i = 0; i < NI; i++) xbuf[i] = 32'(i + 1);
    endtask

    function automatic logic [31:0] rnd(input int sh);
        logic [31:0] r = $urandom;
        return 32'($signed(r) >>> sh);
    endfunction

    task automatic fill_random(input int sh);
        for (int a = 0; a < NI * NO; a++) mem[WB + a] = rnd(sh);
        for (int j = 0; j < NO; j++) mem[BB + j] = rnd(sh);
        for (int i = 0; i < NI; i++) xbuf[i] = rnd(sh);
    endtask

    task automatic check_basic_log(input string tag);
`ifdef FC_RELU_EN
        logic [31:0] y1 = 32'h0000_0000;
`else
        logic [31:0] y1 = 32'hFFFF_FFF6;
`endif
        chk({tag, "_ycount"}, 64'(lg_n), 64'(2));
        chk({tag, "_y0_cycle"}, 64'(lg_rel[0]), 64'(7));
        chk({tag, "_y0_data"}, 64'(lg_d[0]), 64'(20));
        chk({tag, "_y0_idx"}, 64'(lg_i[0]), 64'(0));
        chk({tag, "_y1_cycle"}, 64'(lg_rel[1]), 64'(13));
        chk({tag, "_y1_data"}, 64'(lg_d[1]), 64'(y1));
        chk({tag, "_y1_idx"}, 64'(lg_i[1]), 64'(1));
        chk({tag, "_done_cycle"}, 64'(done_rel), 64'(13));
        chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    endtask

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = '0;
        for (int i = 0; i < 4; i++) xbuf[i] = '0;
        clear_log();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_y_data", 64'(y_data), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_w_addr", 64'(w_addr), 64'(0));
        tick();

        // Fixed-point single-neuron instance
        b_start = 1'b1; tick(); b_start = 1'b0;
        @(negedge clk); chk("fx_busy_c1", 64'(b_busy), 64'(1));
        @(negedge clk);
        @(negedge clk); chk("fx_done_c3", 64'(b_done), 64'(0));
        chk("fx_yv_c3", 64'(b_y_valid), 64'(0));
        @(negedge clk); chk("fx_done_c4", 64'(b_done), 64'(1));
        chk("fx_yv_c4", 64'(b_y_valid), 64'(1));
        chk("fx_y_data", 64'(b_y_data), 64'(32'h0003_8000));
        chk("fx_y_idx", 64'(b_y_idx), 64'(0));
        tick(); tick();

        // Basic pass
        fill_basic(); clear_log();
        start_pulse(); wait_done(100); tick(); tick();
        check_basic_log("basic");

        // Saturation both ways
        for (int a = 0; a < NI * NO; a++) mem[WB + a] = '0;
        mem[WB + 0] = 32'h7FFF_FFFF; mem[WB + 1] = 32'h7FFF_FFFF;
        mem[WB + 4] = 32'h8000_0000; mem[WB + 5] = 32'h8000_0000;
        mem[BB] = '0; mem[BB + 1] = '0;
        xbuf[0] = 32'h7FFF_FFFF; xbuf[1] = 32'h7FFF_FFFF; xbuf[2] = '0; xbuf[3] = '0;
        clear_log();
        start_pulse(); wait_done(100); tick(); tick();
        chk("sat_pos", 64'(lg_d[0]), 64'(32'h7FFF_FFFF));
`ifdef FC_RELU_EN
        chk("sat_neg", 64'(lg_d[1]), 64'(32'h0000_0000));
`else
        chk("sat_neg", 64'(lg_d[1]), 64'(32'h8000_0000));
`endif

        // Start pulse during a running pass is ignored
        fill_basic(); clear_log();
        start_pulse(); tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(100); tick(); tick();
        check_basic_log("ignored_start");

        // start held high across done re-launches after one IDLE cycle
        clear_log();
        start = 1'b1;
        wait_done(100);
        @(negedge clk); chk("held_idle_busy", 64'(busy), 64'(0));
        @(negedge clk); chk("held_rerun_busy", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done(100); tick(); tick();
        chk("held_done_count", 64'(done_cnt), 64'(2));

        // Reset in the middle of RUN
        fill_basic(); clear_log();
        start_pulse(); repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_w_rd", 64'(w_rd), 64'(0));
        chk("mid_rst_x_rd", 64'(x_rd), 64'(0));
        chk("mid_rst_y_valid", 64'(y_valid), 64'(0));
        chk("mid_rst_y_data", 64'(y_data), 64'(0));
        repeat (20) tick();
        chk("mid_rst_no_done", 64'(done_cnt), 64'(0));
        clear_log();
        start_pulse(); wait_done(100); tick(); tick();
        check_basic_log("after_rst");

        // Randomised passes against the model
        for (int p = 0; p < 12; p++) begin
            int shs [3] = '{1, 15, 19};
            fill_random(shs[p % 3]);
            start_pulse(); wait_done(100);
            repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
